// File: rtl/mux_scan_n_1.sv
// rtl/mux_scan_n_1.sv - registered N:1 channel mux with manual select and round-robin scan
module mux_scan_n_1 #(
    parameter int N     = 8,
    parameter int W     = 8,
    parameter int SEL_W = 3,
    parameter int DWELL = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N*W-1:0]   d,
    input  logic [SEL_W-1:0] sel,
    input  logic             mode,
    input  logic             en,
    output logic [W-1:0]     q,
    output logic [SEL_W-1:0] q_ch,
    output logic             q_valid,
    input  logic             q_ready,
    output logic             sel_err
);

    typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_t;

    localparam int               DW_W     = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW_W-1:0]  DW_MAX   = DW_W'(DWELL - 1);
    localparam logic [SEL_W:0]   N_EXT    = (SEL_W + 1)'(N);
    localparam logic [SEL_W-1:0] PTR_LAST = SEL_W'(N - 1);

    state_t            state;
    logic [SEL_W-1:0]  ptr;
    logic [DW_W-1:0]   dwell_cnt;

    logic              free;
    logic              sel_bad;
    logic              man_cap;
    logic              scan_entry;
    logic              scan_cap;
    logic [W-1:0]      man_data;
    logic [W-1:0]      scan_data;

    // Capture decisions use en/mode as seen on this edge, not the registered state.
    always_comb begin
        free       = !q_valid || q_ready;
        sel_bad    = ({1'b0, sel} >= N_EXT);
        man_cap    = en && !mode && free;
        scan_entry = en && mode && (state != SCAN);
        scan_cap   = en && mode && (state == SCAN) && (dwell_cnt == DW_MAX) && free;
    end

    // Channel lookup by compare loop so an out-of-range select yields zero, never X.
    always_comb begin
        man_data  = '0;
        scan_data = '0;
        for (int i = 0; i < N; i++) begin
            if (sel == SEL_W'(i)) man_data  = d[i*W +: W];
            if (ptr == SEL_W'(i)) scan_data = d[i*W +: W];
        end
    end

    // Mode FSM, scan pointer/dwell and the output holding register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            dwell_cnt <= '0;
            q         <= '0;
            q_ch      <= '0;
            q_valid   <= 1'b0;
            sel_err   <= 1'b0;
        end else begin
            if (!en)       state <= IDLE;
            else if (mode) state <= SCAN;
            else           state <= MANUAL;

            sel_err <= 1'b0;

            if (scan_entry) begin
                ptr       <= '0;
                dwell_cnt <= '0;
            end else if (en && mode) begin
                if (scan_cap) begin
                    dwell_cnt <= '0;
                    ptr       <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
                end else if (dwell_cnt != DW_MAX) begin
                    dwell_cnt <= dwell_cnt + 1'b1;
                end
            end else begin
                dwell_cnt <= '0;
            end

            // A pending sample is only replaced on a free slot, so nothing is dropped.
            if (man_cap) begin
                q       <= sel_bad ? '0 : man_data;
                q_ch    <= sel;
                q_valid <= 1'b1;
                sel_err <= sel_bad;
            end else if (scan_cap) begin
                q       <= scan_data;
                q_ch    <= ptr;
                q_valid <= 1'b1;
            end else if (q_ready) begin
                q_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_scan_n_1.sv
// tb/tb_mux_scan_n_1.sv - self-checking bench for mux_scan_n_1 (N=8/DWELL=4 and N=6/DWELL=1)
module tb_mux_scan_n_1;

    logic        clk;
    logic        rst_n;
    logic [63:0] d;
    logic [2:0]  sel;
    logic        mode;
    logic        en;
    logic        q_ready;

    logic [7:0]  q8, q6;
    logic [2:0]  ch8, ch6;
    logic        v8, v6, err8, err6;

    int total = 0;
    int bad   = 0;

    mux_scan_n_1 #(.N(8), .W(8), .SEL_W(3), .DWELL(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .d(d), .sel(sel), .mode(mode), .en(en),
        .q(q8), .q_ch(ch8), .q_valid(v8), .q_ready(q_ready), .sel_err(err8)
    );

    mux_scan_n_1 #(.N(6), .W(8), .SEL_W(3), .DWELL(1)) dut6 (
        .clk(clk), .rst_n(rst_n), .d(d[47:0]), .sel(sel), .mode(mode), .en(en),
        .q(q6), .q_ch(ch6), .q_valid(v6), .q_ready(q_ready), .sel_err(err6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: index 0 mirrors dut8, index 1 mirrors dut6.
    int   ecount;
    bit   m_scan [2];
    int   m_last [2];
    int   m_next [2];
    int   m_q    [2];
    int   m_ch   [2];
    bit   m_v    [2];
    bit   m_err  [2];
    bit   m_cap  [2];

    function automatic int n_of(int i);
        return (i == 0) ? 8 : 6;
    endfunction

    function automatic int dw_of(int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic int byte_of(int c);
        logic [63:0] t;
        t = d >> (c * 8);
        return int'(t[7:0]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_scan[i] = 0; m_last[i] = 0; m_next[i] = 0;
            m_q[i] = 0; m_ch[i] = 0; m_v[i] = 0; m_err[i] = 0; m_cap[i] = 0;
        end
    endtask

    // One clock edge of behaviour: a slot is free when empty or being drained;
    // scan captures need at least DWELL edges since entry or the previous capture.
    task automatic model_step();
        ecount++;
        for (int i = 0; i < 2; i++) begin
            bit free;
            bit cap;
            int ch;
            int val;
            bit err;
            free = !m_v[i] || q_ready;
            cap = 0; ch = 0; val = 0; err = 0;
            if (!en) begin
                m_scan[i] = 0;
            end else if (!mode) begin
                m_scan[i] = 0;
                if (free) begin
                    cap = 1;
                    ch  = int'(sel);
                    err = (ch >= n_of(i));
                    val = err ? 0 : byte_of(ch);
                end
            end else if (!m_scan[i]) begin
                m_scan[i] = 1;
                m_last[i] = ecount;
                m_next[i] = 0;
            end else if ((ecount - m_last[i]) >= dw_of(i) && free) begin
                cap = 1;
                ch  = m_next[i];
                val = byte_of(ch);
                m_next[i] = (m_next[i] + 1) % n_of(i);
                m_last[i] = ecount;
            end
            m_cap[i] = cap;
            m_err[i] = err;
            if (cap) begin
                m_q[i] = val; m_ch[i] = ch; m_v[i] = 1;
            end else if (q_ready) begin
                m_v[i] = 0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("q8",     32'(q8),   32'(m_q[0]));
        chk("q_ch8",  32'(ch8),  32'(m_ch[0]));
        chk("valid8", 32'(v8),   32'(m_v[0]));
        chk("err8",   32'(err8), 32'(m_err[0]));
        chk("q6",     32'(q6),   32'(m_q[1]));
        chk("q_ch6",  32'(ch6),  32'(m_ch[1]));
        chk("valid6", 32'(v6),   32'(m_v[1]));
        chk("err6",   32'(err6), 32'(m_err[1]));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_q8"},  32'(q8),  0);
        chk({tag, "_ch8"}, 32'(ch8), 0);
        chk({tag, "_v8"},  32'(v8),  0);
        chk({tag, "_e8"},  32'(err8), 0);
        chk({tag, "_q6"},  32'(q6),  0);
        chk({tag, "_v6"},  32'(v6),  0);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic load_pattern();
        for (int i = 0; i < 8; i++) d[i*8 +: 8] = 8'hA0 + 8'(i);
    endtask

    initial begin
        int guard;
        ecount = 0;
        model_reset();
        rst_n = 1'b0; d = '0; sel = '0; mode = 1'b0; en = 1'b0; q_ready = 1'b0;
        #2;
        check_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Manual sweep
        load_pattern();
        en = 1'b1; mode = 1'b0; q_ready = 1'b1;
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            cycle();
            chk("sweep_q", 32'(q8), 32'hA0 + 32'(s));
            chk("sweep_v", 32'(v8), 1);
        end

        // Scan with wrap
        mode = 1'b1;
        for (int k = 0; k < 40; k++) cycle();

        // Backpressure after channel 2 capture
        guard = 0;
        while (!(m_cap[0] && m_ch[0] == 2) && guard < 60) begin
            cycle();
            guard++;
        end
        chk("bp_found", 32'(guard < 60), 1);
        q_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            chk("bp_hold_q", 32'(q8), 32'hA2);
        end
        q_ready = 1'b1;
        cycle();
        chk("bp_next_ch", 32'(ch8), 3);
        for (int k = 0; k < 12; k++) cycle();

        // Out-of-range manual select on the 6-channel instance
        mode = 1'b0; sel = 3'd7;
        cycle();
        chk("oor_q6",   32'(q6),   0);
        chk("oor_ch6",  32'(ch6),  7);
        chk("oor_err6", 32'(err6), 1);
        sel = 3'd5;
        cycle();
        chk("in_q6",   32'(q6),   32'hA5);
        chk("in_err6", 32'(err6), 0);

        // Reset mid-scan
        mode = 1'b1;
        guard = 0;
        while (!(m_v[0] && m_next[0] == 5) && guard < 80) begin
            cycle();
            guard++;
        end
        chk("rst_found", 32'(guard < 80), 1);
        #2 rst_n = 1'b0;
        #1 check_zero("midrst");
        model_reset();
        #2 rst_n = 1'b1;
        for (int k = 0; k < 6; k++) cycle();
        chk("rst_first_ch", 32'(ch8), 0);

        // Disable with a pending sample
        q_ready = 1'b0;
        guard = 0;
        while (!m_v[0] && guard < 20) begin
            cycle();
            guard++;
        end
        en = 1'b0;
        for (int k = 0; k < 4; k++) cycle();
        chk("dis_pending", 32'(v8), 1);
        q_ready = 1'b1;
        for (int k = 0; k < 4; k++) cycle();
        chk("dis_drained", 32'(v8), 0);

        // Randomised traffic
        for (int k = 0; k < 400; k++) begin
            d       = {$urandom, $urandom};
            sel     = 3'($urandom_range(7));
            q_ready = ($urandom_range(3) != 0);
            en      = ($urandom_range(15) != 0);
            if ($urandom_range(15) == 0) mode = ~mode;
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
